// File: rtl/shoe_dealer.sv
// shoe_dealer: multi-deck card shoe that deals 1..MAX_DEAL cards per request without replacement.
// Build option SHOE_DEALER_TEST_SEQ_EN swaps the LFSR candidate for a deterministic 1..13 sequence.
module shoe_dealer #(
    parameter int          NUM_DECKS    = 1,
    parameter int          MAX_DEAL     = 2,
    parameter int          RESHUFFLE_AT = 15,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  deal_req,
    input  logic [2:0]            deal_num,
    input  logic                  shuffle_req,
    output logic [4*MAX_DEAL-1:0] cards,
    output logic                  deal_ack,
    output logic                  deal_err,
    output logic                  busy,
    output logic [8:0]            remaining,
    output logic                  reshuffled
);
    localparam logic [5:0] RANK_FULL = 6'(4 * NUM_DECKS);
    localparam logic [8:0] SHOE_FULL = 9'(52 * NUM_DECKS);
    localparam logic [8:0] RESH_LIM  = 9'(RESHUFFLE_AT);
    localparam logic [2:0] DEAL_MAX  = 3'(MAX_DEAL);

    typedef enum logic [2:0] {S_IDLE, S_DRAW, S_PROBE, S_DONE, S_SHUFFLE} state_t;

    state_t                     state, state_nxt;
    logic [5:0]                 cnt [13];
    logic [8:0]                 rem;
    logic [2:0]                 num, k;
    logic [3:0]                 probe, shuf_rank, cand, sel_rank;
    logic                       pend;
    logic [MAX_DEAL-1:0][3:0]   hold, cards_q;
    logic                       take, start, need_shuf, err_nxt, avail, last;

    function automatic logic [3:0] nxt_rank(input logic [3:0] r);
        return (r == 4'd13) ? 4'd1 : r + 4'd1;
    endfunction

`ifdef SHOE_DEALER_TEST_SEQ_EN
    logic [3:0] seq;
    always_ff @(posedge clk or negedge reset)
        if (!reset)    seq <= 4'd1;
        else if (take) seq <= nxt_rank(seq);
    assign cand = seq;
`else
    logic [15:0] lfsr;
    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    always_ff @(posedge clk or negedge reset)
        if (!reset) lfsr <= LFSR_SEED;
        else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign cand = (lfsr[3:0] % 4'd13) + 4'd1;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        start     = 1'b0;
        err_nxt   = 1'b0;
        sel_rank  = (state == S_PROBE) ? probe : cand;
        avail     = cnt[sel_rank - 4'd1] != 6'd0;
        last      = (k + 3'd1) == num;
        need_shuf = rem < {6'd0, deal_num};
        case (state)
            S_IDLE: begin
                if (shuffle_req) begin
                    state_nxt = S_SHUFFLE;
                end else if (deal_req) begin
                    if (deal_num == 3'd0 || deal_num > DEAL_MAX) begin
                        err_nxt = 1'b1;
                    end else begin
                        start     = 1'b1;
                        state_nxt = need_shuf ? S_SHUFFLE : S_DRAW;
                    end
                end
            end
            S_DRAW: begin
                if (avail) begin
                    take = 1'b1;
                    if (last) state_nxt = S_DONE;
                end else begin
                    state_nxt = S_PROBE;
                end
            end
            S_PROBE: begin
                if (avail) begin
                    take      = 1'b1;
                    state_nxt = last ? S_DONE : S_DRAW;
                end
            end
            S_DONE:    state_nxt = (rem < RESH_LIM) ? S_SHUFFLE : S_IDLE;
            S_SHUFFLE: if (shuf_rank == 4'd13) state_nxt = pend ? S_DRAW : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (state != S_IDLE && deal_req) err_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 13; r++) cnt[r] <= RANK_FULL;
            rem        <= SHOE_FULL;
            num        <= 3'd0;
            k          <= 3'd0;
            probe      <= 4'd1;
            shuf_rank  <= 4'd1;
            pend       <= 1'b0;
            hold       <= '0;
            cards_q    <= '0;
            deal_ack   <= 1'b0;
            deal_err   <= 1'b0;
            reshuffled <= 1'b0;
        end else begin
            deal_ack   <= 1'b0;
            reshuffled <= 1'b0;
            deal_err   <= err_nxt;
            if (start) begin
                num  <= deal_num;
                k    <= 3'd0;
                pend <= need_shuf;
            end
            if (take) begin
                cnt[sel_rank - 4'd1] <= cnt[sel_rank - 4'd1] - 6'd1;
                rem <= rem - 9'd1;
                k   <= k + 3'd1;
                for (int s = 0; s < MAX_DEAL; s++)
                    if (k == 3'(s)) hold[s] <= sel_rank;
            end
            // An empty candidate rank starts a linear walk to the next non-empty rank
            if (state == S_DRAW && !avail)  probe <= nxt_rank(cand);
            if (state == S_PROBE && !avail) probe <= nxt_rank(probe);
            if (state == S_DONE) begin
                deal_ack <= 1'b1;
                for (int s = 0; s < MAX_DEAL; s++)
                    cards_q[s] <= (3'(s) < num) ? hold[s] : 4'd0;
            end
            if (state == S_SHUFFLE) begin
                cnt[shuf_rank - 4'd1] <= RANK_FULL;
                shuf_rank <= shuf_rank + 4'd1;
                if (shuf_rank == 4'd13) begin
                    shuf_rank  <= 4'd1;
                    rem        <= SHOE_FULL;
                    reshuffled <= 1'b1;
                    pend       <= 1'b0;
                end
            end
        end
    end

    assign cards     = cards_q;
    assign busy      = (state != S_IDLE);
    assign remaining = rem;

endmodule

// File: doc/shoe_dealer.md
# shoe_dealer

- Parametrised multi-deck card shoe for the blackjack datapath.
- Deals 1..MAX_DEAL cards per request without replacement from NUM_DECKS standard decks, using a request/acknowledge handshake.
- Tracks per-rank counts and reshuffles automatically when the shoe runs low.
- Sits between the game controller and the hand/score logic; card encoding is 4-bit rank, 1 = Ace … 13 = King, 0 = no card.

## Interface

Parameters:
- NUM_DECKS, 1 — decks in the shoe; legal range 1..8.
- MAX_DEAL, 2 — maximum cards per request; legal range 1..4.
- RESHUFFLE_AT, 15 — after a deal, reshuffle if remaining < this value.
- LFSR_SEED, 16'hACE1 — LFSR reset value; must be nonzero.

Ports:
- clk  in  1  — clock; all state updates on the rising edge.
- reset  in  1  — asynchronous, active-low reset.
- deal_req  in  1  — single-cycle deal request pulse.
- deal_num  in  3  — cards requested; sampled with deal_req.
- shuffle_req  in  1  — single-cycle forced reshuffle pulse.
- cards  out  4*MAX_DEAL  — dealt ranks; slot k is bits [4k+3:4k].
- deal_ack  out  1  — one-cycle pulse; cards valid from this cycle.
- deal_err  out  1  — one-cycle pulse; request rejected.
- busy  out  1  — high in every non-IDLE state.
- remaining  out  9  — cards left in the shoe.
- reshuffled  out  1  — one-cycle pulse when a shuffle completes.

## Operation

- Per-rank counters: 13 × 6 bits, each loaded with 4*NUM_DECKS.
- remaining equals the sum of the per-rank counters.
- Candidate source: 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1.
  - Steps every cycle while out of reset.
  - Candidate rank = (lfsr[3:0] mod 13) + 1.
- FSM states: IDLE, DRAW, PROBE, DONE, SHUFFLE.
- IDLE:
  - shuffle_req → SHUFFLE. If deal_req arrives in the same cycle, shuffle wins and the deal pulse is dropped without deal_err.
  - deal_req with deal_num == 0 or deal_num > MAX_DEAL → deal_err, stay IDLE.
  - Valid deal_req → latch deal_num, clear slot index k to 0.
    - If remaining < deal_num, go to SHUFFLE first; the deal resumes in DRAW afterwards.
    - Otherwise go to DRAW.
- DRAW:
  - If count[candidate] > 0: decrement it, decrement remaining, write the rank into the slot-k holding register, k++.
  - Otherwise latch probe = candidate mod 13 + 1 and go to PROBE.
  - When k reaches deal_num → DONE.
- PROBE: one rank per cycle.
  - If count[probe] > 0: take it as in DRAW, then return to DRAW, or go to DONE if this was the last card.
  - Otherwise probe = probe mod 13 + 1.
  - Bounded to 12 cycles, since remaining ≥ 1 is guaranteed.
- DONE:
  - Copy holding slots to cards; slots ≥ deal_num are driven 0.
  - Pulse deal_ack.
  - If remaining < RESHUFFLE_AT → SHUFFLE, else → IDLE.
- SHUFFLE:
  - Reload one rank counter per cycle, ranks 1..13 (13 cycles).
  - remaining is set to 52*NUM_DECKS in the final cycle, together with the reshuffled pulse.
  - Next state: the pending deal (DRAW) if one is queued, else IDLE.
- deal_req while busy → dropped, deal_err pulse.
- shuffle_req while busy → ignored.
- cards holds its value until the next deal_ack.

## Timing

- Reset (reset low) values:
  - cards = 0, deal_ack = 0, deal_err = 0, busy = 0, reshuffled = 0.
  - remaining = 52*NUM_DECKS; every rank count = 4*NUM_DECKS.
  - lfsr = LFSR_SEED; state = IDLE.
- Reset asserted mid-deal or mid-shuffle:
  - Aborts the operation immediately; no deal_ack.
  - Shoe returns to full.
- Valid request sampled at edge t:
  - busy high from t+1.
  - Cards drawn at edges t+1 .. t+n when no probing occurs.
  - Each probe step adds one cycle.
  - deal_ack and new cards visible in the cycle after the edge where DONE is entered.
  - Minimum latency from request to deal_ack: n+1 cycles.
- deal_err is asserted in the cycle after the offending pulse.
- Auto-shuffle after a deal adds 13 busy cycles after deal_ack.
- Pre-deal shuffle adds 13 cycles before the first draw.

## Configuration

- Macro: SHOE_DEALER_TEST_SEQ_EN.
- Defined:
  - The candidate comes from a 4-bit sequence counter instead of the LFSR.
  - Counter resets to 1, advances 1→2→…→13→1 on each card taken (DRAW or PROBE).
  - Dealing is fully deterministic for the bench.
- Undefined:
  - LFSR candidate as specified above.
  - No sequence counter is present.

## Test plan

All scenarios use SHOE_DEALER_TEST_SEQ_EN defined, NUM_DECKS=1, MAX_DEAL=2, RESHUFFLE_AT=15.

- Reset, then deal_req with deal_num=2 → deal_ack 3 cycles after request, cards=8'h21, remaining=50, busy low afterwards.
- deal_num=1 after the previous deal → cards=8'h03 (slot1 zeroed), remaining=49.
- deal_num=0, then deal_num=3, then deal_req during busy → deal_err pulse each time; cards and remaining unchanged.
- RESHUFFLE_AT=0, 52 single-card deals → each rank appears exactly 4 times, remaining=0. A further deal triggers a pre-deal shuffle: reshuffled pulse, then cards=8'h01 and remaining=51.
- Deal until remaining=14 → deal_ack followed by 13 busy cycles, reshuffled pulse, remaining=52.
- reset pulsed low mid-DRAW → no deal_ack, cards=0, remaining=52, state IDLE.
